// File: rtl/dac_table_axim_deadlock_report_if.sv
`default_nettype none
// ============================================================================
//  Module   : dac_table_axim_deadlock_report_if
//  Brief    : Monitor/host-facing signal bundle of the deadlock report block.
//  Revision : 1.0  initial release
// ============================================================================
interface dac_table_axim_deadlock_report_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 16
);
    localparam int c_ch_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                       block;
    logic [NUM_CH*NUM_CH-1:0]   axis_block_info;
    logic                       clear;
    logic                       deadlock;
    logic                       irq;
    logic [NUM_CH-1:0]          blocked_mask;
    logic [c_ch_w-1:0]          blocked_ch;
    logic [NUM_CH*NUM_CH-1:0]   snapshot;
    logic                       proto_err;
    logic [CNT_W-1:0]           event_count;

    // Monitor plus host side
    modport master (
        output block, axis_block_info, clear,
        input  deadlock, irq, blocked_mask, blocked_ch, snapshot, proto_err, event_count
    );

    // Report block side
    modport slave (
        input  block, axis_block_info, clear,
        output deadlock, irq, blocked_mask, blocked_ch, snapshot, proto_err, event_count
    );
endinterface
`default_nettype wire

// File: rtl/dac_table_axim_deadlock_report.sv
`default_nettype none
// ============================================================================
//  Module   : dac_table_axim_deadlock_report
//  Brief    : Qualifies a persistent monitor block flag, latches which AXIS
//             channels were blocked, raises sticky status, irq and event count.
//  Revision : 1.0  initial release
// ============================================================================
module dac_table_axim_deadlock_report #(
    parameter int NUM_CH = 3,
    parameter int THRESH = 16,
    parameter int CNT_W  = 16
) (
    input  wire logic                          clock,
    input  wire logic                          reset,
    dac_table_axim_deadlock_report_if.slave    bus
);
    localparam int              c_ch_w   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int              c_run_w  = $clog2(THRESH + 1);
    localparam bit              c_single = (THRESH == 1);
    localparam logic [c_run_w-1:0] c_last = c_run_w'(THRESH - 1);
    localparam logic [c_run_w-1:0] c_sat  = c_run_w'(THRESH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t                     r_state;
    logic [c_run_w-1:0]         r_run;
    logic                       r_deadlock;
    logic                       r_irq;
    logic [NUM_CH-1:0]          r_blocked_mask;
    logic [c_ch_w-1:0]          r_blocked_ch;
    logic [NUM_CH*NUM_CH-1:0]   r_snapshot;
    logic                       r_proto_err;
    logic [CNT_W-1:0]           r_event_count;

    logic [NUM_CH-1:0]          w_valid;
    logic [NUM_CH-1:0]          w_malformed;
    logic [c_ch_w-1:0]          w_first_ch;
    logic                       w_capture;

    // A well-formed field k has every bit set except its own position.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_field
        localparam logic [NUM_CH-1:0] c_valid_pat = ~(NUM_CH'(1) << k);
        logic [NUM_CH-1:0] w_field;
        assign w_field        = bus.axis_block_info[k*NUM_CH +: NUM_CH];
        assign w_valid[k]     = (w_field == c_valid_pat);
        assign w_malformed[k] = (w_field != '0) && !w_valid[k];
    end

    always_comb begin
        w_first_ch = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_valid[k]) begin
                w_first_ch = c_ch_w'(k);
            end
        end
    end

    // Host clear always beats a qualifying edge.
    assign w_capture = bus.block && !bus.clear &&
                       (((r_state == S_IDLE) && c_single) ||
                        ((r_state == S_ARM) && (r_run == c_last)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_run          <= '0;
            r_deadlock     <= 1'b0;
            r_irq          <= 1'b0;
            r_blocked_mask <= '0;
            r_blocked_ch   <= '0;
            r_snapshot     <= '0;
            r_proto_err    <= 1'b0;
            r_event_count  <= '0;
        end else begin
            r_irq <= 1'b0;

            if (bus.block && (|w_malformed)) begin
                r_proto_err <= 1'b1;
            end else if (bus.clear && ((r_state == S_IDLE) || (r_state == S_LOCKED))) begin
                r_proto_err <= 1'b0;
            end

            if (w_capture) begin
                r_deadlock     <= 1'b1;
                r_irq          <= 1'b1;
                r_snapshot     <= bus.axis_block_info;
                r_blocked_mask <= w_valid;
                r_blocked_ch   <= w_first_ch;
                if (r_event_count != {CNT_W{1'b1}}) begin
                    r_event_count <= r_event_count + CNT_W'(1);
                end
            end

            case (r_state)
                S_IDLE: begin
                    r_run <= '0;
                    if (bus.block && !bus.clear) begin
                        if (c_single) begin
                            r_state <= S_LOCKED;
                        end else begin
                            r_state <= S_ARM;
                            r_run   <= c_run_w'(1);
                        end
                    end
                end
                S_ARM: begin
                    if (bus.clear || !bus.block) begin
                        r_state <= S_IDLE;
                        r_run   <= '0;
                    end else if (r_run == c_last) begin
                        r_state <= S_LOCKED;
                        r_run   <= '0;
                    end else if (r_run != c_sat) begin
                        r_run <= r_run + c_run_w'(1);
                    end
                end
                S_LOCKED: begin
                    if (bus.clear) begin
                        r_state    <= S_IDLE;
                        r_deadlock <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_run   <= '0;
                end
            endcase
        end
    end

    assign bus.deadlock     = r_deadlock;
    assign bus.irq          = r_irq;
    assign bus.blocked_mask = r_blocked_mask;
    assign bus.blocked_ch   = r_blocked_ch;
    assign bus.snapshot     = r_snapshot;
    assign bus.proto_err    = r_proto_err;
    assign bus.event_count  = r_event_count;

endmodule
`default_nettype wire
